// File: rtl/lsu_read_arbiter.sv
// Round-robin arbiter sharing one memory read channel among several load units.
// One read is outstanding at a time; data returns only to the granted consumer.
module lsu_read_arbiter #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid_i,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address_i,
  output logic [NUM_CONSUMERS-1:0]           consumer_read_ready_o,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data_o,
  output logic                               mem_read_valid_o,
  output logic [ADDR_BITS-1:0]               mem_read_address_o,
  input  logic                               mem_read_ready_i,
  input  logic [DATA_BITS-1:0]               mem_read_data_i
);

  localparam int IdW = $clog2(NUM_CONSUMERS);

  typedef enum logic [1:0] {
    IDLE,
    READ_WAITING,
    RELAYING
  } state_e;

  state_e                           state_q, state_d;
  logic [IdW-1:0]                   grantId_q, grantId_d;
  logic [IdW-1:0]                   lastGrant_q, lastGrant_d;
  logic                             memValid_q, memValid_d;
  logic [ADDR_BITS-1:0]             memAddr_q, memAddr_d;
  logic [NUM_CONSUMERS-1:0]         ready_q, ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] data_q, data_d;

  logic           winnerFound;
  logic [IdW-1:0] winnerId;
  logic [IdW-1:0] candId;

  // Search starts just after the last served consumer, so it drops to lowest priority.
  always_comb begin
    winnerFound = 1'b0;
    winnerId    = '0;
    candId      = '0;
    for (int k = 1; k <= NUM_CONSUMERS; k++) begin
      candId = IdW'((int'(lastGrant_q) + k) % NUM_CONSUMERS);
      if (!winnerFound && consumer_read_valid_i[candId]) begin
        winnerFound = 1'b1;
        winnerId    = candId;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grantId_d   = grantId_q;
    lastGrant_d = lastGrant_q;
    memValid_d  = memValid_q;
    memAddr_d   = memAddr_q;
    ready_d     = ready_q;
    data_d      = data_q;
    case (state_q)
      IDLE: begin
        if (winnerFound) begin
          grantId_d  = winnerId;
          memValid_d = 1'b1;
          memAddr_d  = consumer_read_address_i[winnerId*ADDR_BITS +: ADDR_BITS];
          state_d    = READ_WAITING;
        end
      end
      READ_WAITING: begin
        if (mem_read_ready_i) begin
          memValid_d                                 = 1'b0;
          data_d[grantId_q*DATA_BITS +: DATA_BITS]   = mem_read_data_i;
          ready_d[grantId_q]                         = 1'b1;
          state_d                                    = RELAYING;
        end
      end
      RELAYING: begin
        if (!consumer_read_valid_i[grantId_q]) begin
          ready_d     = '0;
          lastGrant_d = grantId_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grantId_q   <= '0;
      lastGrant_q <= IdW'(NUM_CONSUMERS - 1);
      memValid_q  <= 1'b0;
      memAddr_q   <= '0;
      ready_q     <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      grantId_q   <= grantId_d;
      lastGrant_q <= lastGrant_d;
      memValid_q  <= memValid_d;
      memAddr_q   <= memAddr_d;
      ready_q     <= ready_d;
      data_q      <= data_d;
    end
  end

  assign consumer_read_ready_o = ready_q;
  assign consumer_read_data_o  = data_q;
  assign mem_read_valid_o      = memValid_q;
  assign mem_read_address_o    = memAddr_q;

endmodule

// File: tb/tb_lsu_read_arbiter.sv
// Scoreboard bench for lsu_read_arbiter: expected memory addresses and returned
// data are queued by the stimulus and checked by a monitor on each DUT event.
module tb_lsu_read_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct packed {
    logic [1:0]    lane;
    logic [DW-1:0] data;
  } resp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    consumerValid;
  logic [N*AW-1:0] consumerAddr;
  logic [N-1:0]    readyBus;
  logic [N*DW-1:0] dataBus;
  logic            memValid;
  logic [AW-1:0]   memAddr;
  logic            memReady;
  logic [DW-1:0]   memData;

  logic [AW-1:0] expAddrQ[$];
  resp_t         expRespQ[$];
  int            checksTotal = 0;
  int            checksPassed = 0;

  int            reqLeft[N];
  logic [AW-1:0] nextAddr[N];
  int            holdCnt[N];
  int            holdCycles = 0;
  int            memDelay = 2;
  bit            memTied = 1'b0;

  lsu_read_arbiter #(.NUM_CONSUMERS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid_i  (consumerValid),
    .consumer_read_address_i(consumerAddr),
    .consumer_read_ready_o  (readyBus),
    .consumer_read_data_o   (dataBus),
    .mem_read_valid_o       (memValid),
    .mem_read_address_o     (memAddr),
    .mem_read_ready_i       (memReady),
    .mem_read_data_i        (memData)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int consumer, input int count, input logic [AW-1:0] base);
    nextAddr[consumer] = base;
    reqLeft[consumer]  = count;
  endtask

  task automatic pushExpect(input logic [AW-1:0] addr, input logic [1:0] lane, input logic [DW-1:0] data);
    resp_t r;
    r.lane = lane;
    r.data = data;
    expAddrQ.push_back(addr);
    expRespQ.push_back(r);
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    expAddrQ.delete();
    expRespQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " mem_valid"}, 32'(memValid), 32'd0);
    checkOutput({tag, " mem_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, " ready"}, 32'(readyBus), 32'd0);
    checkOutput({tag, " data"}, dataBus, 32'd0);
  endtask

  task automatic waitDone(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      done = (expAddrQ.size() == 0) && (expRespQ.size() == 0) && (consumerValid == '0) &&
             (reqLeft[0] == 0) && (reqLeft[1] == 0) && (reqLeft[2] == 0) && (reqLeft[3] == 0) &&
             (readyBus == '0) && !memValid;
    end
    if (!done) begin
      checksTotal++;
      $display("[TB] FAIL %s timeout: got pending addr=%0d resp=%0d, expected 0/0",
               name, expAddrQ.size(), expRespQ.size());
    end
  endtask

  // Consumer agents: raise a request, hold it until served, then drop valid.
  initial begin
    consumerValid = '0;
    consumerAddr  = '0;
    for (int i = 0; i < N; i++) begin
      reqLeft[i] = 0;
      holdCnt[i] = 0;
      nextAddr[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (consumerValid[i] && readyBus[i]) begin
          if (holdCnt[i] < holdCycles) holdCnt[i]++;
          else begin
            consumerValid[i] = 1'b0;
            holdCnt[i] = 0;
          end
        end else if (!consumerValid[i] && !readyBus[i] && reqLeft[i] > 0) begin
          consumerValid[i] = 1'b1;
          consumerAddr[i*AW +: AW] = nextAddr[i];
          nextAddr[i] = nextAddr[i] + 8'd1;
          reqLeft[i]--;
        end
      end
    end
  end

  // Memory model: data = address ^ 0x99, returned memDelay cycles after the request.
  initial begin
    int waitCnt;
    waitCnt  = 0;
    memReady = 1'b0;
    memData  = '0;
    forever begin
      @(negedge clk);
      if (memTied) begin
        memReady = 1'b1;
        memData  = memAddr ^ 8'h99;
      end else if (memReady) begin
        memReady = 1'b0;
        waitCnt  = 0;
      end else if (memValid) begin
        waitCnt++;
        if (waitCnt >= memDelay) begin
          memReady = 1'b1;
          memData  = memAddr ^ 8'h99;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  initial begin
    logic            prevMemValid;
    logic [N-1:0]    prevReady;
    logic [AW-1:0]   heldAddr;
    logic [N*DW-1:0] modelBus;
    logic [1:0]      curLane;
    int              cycle;
    int              riseCycle;
    resp_t           r;
    prevMemValid = 1'b0;
    prevReady    = '0;
    heldAddr     = '0;
    modelBus     = '0;
    curLane      = '0;
    cycle        = 0;
    riseCycle    = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        modelBus     = '0;
        prevMemValid = 1'b0;
        prevReady    = '0;
      end else begin
        if (memValid && !prevMemValid) begin
          riseCycle = cycle;
          heldAddr  = memAddr;
          if (expAddrQ.size() == 0) checkOutput("unexpected mem request", 32'(memAddr), 32'hFFFF_FFFF);
          else checkOutput("mem address", 32'(memAddr), 32'(expAddrQ.pop_front()));
        end else if (memValid) begin
          checkOutput("mem address stable", 32'(memAddr), 32'(heldAddr));
        end
        if (readyBus != '0 && prevReady == '0) begin
          if (expRespQ.size() == 0) begin
            checkOutput("unexpected ready", 32'(readyBus), 32'd0);
          end else begin
            r = expRespQ.pop_front();
            curLane = r.lane;
            checkOutput("ready one-hot", 32'(readyBus), 32'(4'b0001 << r.lane));
            modelBus[r.lane*DW +: DW] = r.data;
            if (memTied) checkOutput("same-cycle latency", 32'(cycle - riseCycle), 32'd1);
          end
        end else if (readyBus != '0) begin
          checkOutput("ready held", 32'(readyBus), 32'(4'b0001 << curLane));
        end
        checkOutput("data lanes", dataBus, modelBus);
        prevMemValid = memValid;
        prevReady    = readyBus;
      end
    end
  end

  initial begin
    int count;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b0;

    // Single request, memory answers after 3 cycles, consumer holds valid a while.
    holdCycles = 3;
    memDelay   = 3;
    pushExpect(8'h3C, 2'd2, 8'hA5);
    applyStimulus(2, 1, 8'h3C);
    waitDone("single");

    applyReset();
    holdCycles = 0;
    memDelay   = 2;
    pushExpect(8'h10, 2'd0, 8'h89);
    pushExpect(8'h11, 2'd1, 8'h88);
    pushExpect(8'h12, 2'd2, 8'h8B);
    pushExpect(8'h13, 2'd3, 8'h8A);
    for (int i = 0; i < N; i++) applyStimulus(i, 1, 8'h10 + 8'(i));
    waitDone("simultaneous");

    applyReset();
    pushExpect(8'h40, 2'd0, 8'hD9);
    pushExpect(8'h70, 2'd3, 8'hE9);
    pushExpect(8'h41, 2'd0, 8'hD8);
    pushExpect(8'h71, 2'd3, 8'hE8);
    pushExpect(8'h42, 2'd0, 8'hDB);
    pushExpect(8'h72, 2'd3, 8'hEB);
    applyStimulus(0, 3, 8'h40);
    applyStimulus(3, 3, 8'h70);
    waitDone("fairness");

    applyReset();
    memDelay = 21;
    pushExpect(8'h5E, 2'd1, 8'hC7);
    applyStimulus(1, 1, 8'h5E);
    count = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (readyBus != '0) break;
      if (memValid) count++;
    end
    checkOutput("stall valid cycles", 32'(count), 32'd21);
    waitDone("stall");

    // Reset while consumer 1 is waiting on memory; consumer 0 must win afterwards.
    applyReset();
    memDelay = 100;
    expAddrQ.push_back(8'h21);
    applyStimulus(1, 1, 8'h21);
    for (int c = 0; c < 50 && !memValid; c++) @(negedge clk);
    checkOutput("resetmid granted", 32'(memValid), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetOutputs("resetmid");
    expAddrQ.delete();
    expRespQ.delete();
    memDelay = 2;
    pushExpect(8'h05, 2'd0, 8'h9C);
    pushExpect(8'h21, 2'd1, 8'hB8);
    applyStimulus(0, 1, 8'h05);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    waitDone("resetmid");

    applyReset();
    memTied = 1'b1;
    pushExpect(8'h80, 2'd0, 8'h19);
    pushExpect(8'h81, 2'd1, 8'h18);
    pushExpect(8'h82, 2'd2, 8'h1B);
    pushExpect(8'h83, 2'd3, 8'h1A);
    for (int i = 0; i < N; i++) applyStimulus(i, 1, 8'h80 + 8'(i));
    waitDone("tied ready");
    memTied = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
